// File: rtl/sram_rw_ctrl_pkg.sv
// Shared geometry and state encoding for the SRAM access controller.
// Sized for the 128 x 104-bit macro with eight 13-bit write lanes.
package sram_ctrl_pkg;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int LANES  = 8;
    localparam int LANE_W = 13;
    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_rw_ctrl_if.sv
// Request, response and macro-side signals of the SRAM access controller.
// The controller uses the slave view; the requester and macro side use master.
interface sram_rw_ctrl_if;
    import sram_ctrl_pkg::*;

    logic              wreq_valid;
    logic              wreq_ready;
    logic [ADDR_W-1:0] wreq_addr;
    logic [LANES-1:0]  wreq_mask;
    logic [DATA_W-1:0] wreq_data;
    logic              rreq_valid;
    logic              rreq_ready;
    logic [ADDR_W-1:0] rreq_addr;
    logic              rresp_valid;
    logic              rresp_ready;
    logic [DATA_W-1:0] rresp_data;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [LANES-1:0]  sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              init_done;

    modport slave (
        input  wreq_valid, wreq_addr, wreq_mask, wreq_data,
        input  rreq_valid, rreq_addr, rresp_ready, sram_rdata,
        output wreq_ready, rreq_ready, rresp_valid, rresp_data,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_done
    );

    modport master (
        output wreq_valid, wreq_addr, wreq_mask, wreq_data,
        output rreq_valid, rreq_addr, rresp_ready, sram_rdata,
        input  wreq_ready, rreq_ready, rresp_valid, rresp_data,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_done
    );

endinterface

// File: rtl/sram_resp_buf.sv
// Two-entry valid/ready FIFO holding read data captured from the macro.
// Has no input ready: the controller's credit count guarantees it never overflows.
module sram_resp_buf
    import sram_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              pop;

    assign pop         = out_valid_o & out_ready_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (in_valid_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop)        rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, in_valid_i} - {1'b0, pop};
        end
    end

    // NOTE: the storage is not reset; the data output is forced to zero while empty instead.
    always_ff @(posedge clock) begin
        if (in_valid_i) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/sram_rw_ctrl.sv
// Arbitrates read and write requests onto the single RW port of the SRAM macro,
// zero-fills the array after reset, and buffers read data behind a credit check.
module sram_rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter bit INIT_EN    = 1'b1
) (
    input logic           clock,
    input logic           reset_n,
    sram_rw_ctrl_if.slave bus
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    state_e              state_q;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic                inflight_q;
    logic [STARVE_W-1:0] starve_q;

    logic                run;
    logic                pop;
    logic [1:0]          occ;
    logic [2:0]          credit_cnt;
    logic                credit_ok;
    logic                starved;
    logic                read_pri;
    logic                rgrant;
    logic                wgrant;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_data;

    // Outputs are qualified with reset_n so everything reads zero while reset is held.
    assign run        = reset_n && (state_q == RUN);
    assign pop        = resp_valid & bus.rresp_ready;
    assign credit_cnt = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign credit_ok  = (credit_cnt < 3'd2);
    assign starved    = (starve_q == STARVE_TOP);
    assign read_pri   = bus.rreq_valid & credit_ok & (~bus.wreq_valid | starved);
    assign rgrant     = run & read_pri;
    assign wgrant     = run & bus.wreq_valid & ~read_pri;

    assign bus.wreq_ready  = run & ~read_pri;
    assign bus.rreq_ready  = run & credit_ok & (~bus.wreq_valid | starved);
    assign bus.init_done   = run;
    assign bus.rresp_valid = resp_valid;
    assign bus.rresp_data  = resp_data;

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_wmode = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wmask = '0;
        bus.sram_wdata = '0;
        if (reset_n) begin
            if (state_q == INIT) begin
                bus.sram_en    = 1'b1;
                bus.sram_wmode = 1'b1;
                bus.sram_addr  = init_cnt_q;
                bus.sram_wmask = '1;
            end else if (wgrant) begin
                bus.sram_en    = 1'b1;
                bus.sram_wmode = 1'b1;
                bus.sram_addr  = bus.wreq_addr;
                bus.sram_wmask = bus.wreq_mask;
                bus.sram_wdata = bus.wreq_data;
            end else if (rgrant) begin
                bus.sram_en    = 1'b1;
                bus.sram_addr  = bus.rreq_addr;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if (INIT_EN) state_q <= INIT;
            else         state_q <= RUN;
            init_cnt_q <= '0;
            inflight_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            inflight_q <= rgrant;
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == ADDR_W'(DEPTH - 1)) state_q <= RUN;
                end
                RUN: begin
                    // Only a read that had credit but lost to a write counts toward starvation.
                    if (rgrant || !bus.rreq_valid)
                        starve_q <= '0;
                    else if (wgrant && credit_ok && !starved)
                        starve_q <= starve_q + 1'b1;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    sram_resp_buf u_resp_buf (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid_i  (inflight_q),
        .in_data_i   (bus.sram_rdata),
        .out_valid_o (resp_valid),
        .out_ready_i (bus.rresp_ready),
        .out_data_o  (resp_data),
        .count_o     (occ)
    );

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl with a behavioural model of the masked SRAM macro.
// Unwritten entries read back as a poison pattern so a skipped zero-fill shows up.
module tb_sram_rw_ctrl;
    import sram_ctrl_pkg::*;

    localparam logic [DATA_W-1:0] POISON = {8{13'h0A5A}};

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sram_rw_ctrl_if bus ();

    sram_rw_ctrl #(.STARVE_MAX(4), .INIT_EN(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    bit                written [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always @(posedge clock) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                for (int l = 0; l < LANES; l++)
                    if (bus.sram_wmask[l])
                        mem[bus.sram_addr][l*LANE_W +: LANE_W] <= bus.sram_wdata[l*LANE_W +: LANE_W];
                written[bus.sram_addr] <= 1'b1;
            end else begin
                rdata_q <= written[bus.sram_addr] ? mem[bus.sram_addr] : POISON;
            end
        end
    end
    assign bus.sram_rdata = rdata_q;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [LANE_W-1:0] l;
        l = LANE_W'(i * 37 + 5);
        return {LANES{l}};
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctrl"}, {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask,
                               bus.wreq_ready, bus.rreq_ready, bus.rresp_valid, bus.init_done}, '0);
        check({tag, "_wdata"}, bus.sram_wdata, '0);
        check({tag, "_rdata"}, bus.rresp_data, '0);
    endtask

    // Releases reset on a falling edge and checks the full zero-fill sweep.
    task automatic release_and_check_init(input string tag);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check({tag, "_sweep"},
                  {bus.sram_wdata, bus.sram_en, bus.sram_wmode, bus.sram_wmask, bus.sram_addr, bus.init_done},
                  {104'h0, 1'b1, 1'b1, 8'hFF, 7'(k), 1'b0});
            @(negedge clock);
        end
        #1;
        check({tag, "_done"}, {bus.init_done, bus.sram_en}, 2'b10);
        tick();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
        bus.wreq_valid = 1'b1;
        bus.wreq_addr  = a;
        bus.wreq_mask  = m;
        bus.wreq_data  = d;
        #1;
        for (int b = 0; b < 20 && !bus.wreq_ready; b++) tick();
        check("wr_ready", bus.wreq_ready, 1'b1);
        tick();
        bus.wreq_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        bus.rreq_valid = 1'b1;
        bus.rreq_addr  = a;
        #1;
        for (int b = 0; b < 20 && !bus.rreq_ready; b++) tick();
        check("rd_ready", bus.rreq_ready, 1'b1);
        tick();
        bus.rreq_valid = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [DATA_W-1:0] exp);
        bus.rresp_ready = 1'b1;
        #1;
        for (int b = 0; b < 20 && !bus.rresp_valid; b++) tick();
        check({tag, "_valid"}, bus.rresp_valid, 1'b1);
        check({tag, "_data"}, bus.rresp_data, exp);
        tick();
    endtask

    initial begin
        int j;
        bus.wreq_valid  = 1'b0;
        bus.wreq_addr   = '0;
        bus.wreq_mask   = '0;
        bus.wreq_data   = '0;
        bus.rreq_valid  = 1'b0;
        bus.rreq_addr   = '0;
        bus.rresp_ready = 1'b1;

        #12;
        check_reset_outs("reset");
        release_and_check_init("init");

        do_read(7'd5);
        get_resp("rd5_zero", '0);

        do_write(7'd3, 8'h01, '1);
        do_read(7'd3);
        check("lat_t1", bus.rresp_valid, 1'b0);
        tick();
        check("lat_t2", {bus.rresp_valid, bus.rresp_data}, {1'b1, 104'h1FFF});
        tick();

        // Simultaneous write and read to one address: write first, read sees merged lane 7.
        bus.wreq_valid = 1'b1; bus.wreq_addr = 7'd7; bus.wreq_mask = 8'h80; bus.wreq_data = '1;
        bus.rreq_valid = 1'b1; bus.rreq_addr = 7'd7;
        #1;
        check("same_arb", {bus.wreq_ready, bus.rreq_ready}, 2'b10);
        tick();
        bus.wreq_valid = 1'b0;
        #1;
        check("same_rgrant", bus.rreq_ready, 1'b1);
        tick();
        bus.rreq_valid = 1'b0;
        check("same_t1", bus.rresp_valid, 1'b0);
        tick();
        check("same_t2", {bus.rresp_valid, bus.rresp_data}, {1'b1, 13'h1FFF, 91'h0});
        tick();

        // Starvation: W,W,W,W,R,W,W,W,W,R with both requests held valid.
        for (int c = 0; c < 10; c++) begin
            bus.wreq_valid = 1'b1; bus.wreq_addr = 7'(100 + c); bus.wreq_mask = '1; bus.wreq_data = pat(c);
            bus.rreq_valid = 1'b1; bus.rreq_addr = 7'd100;
            #1;
            check($sformatf("starve_c%0d", c), {bus.wreq_ready, bus.rreq_ready},
                  (c == 4 || c == 9) ? 2'b01 : 2'b10);
            tick();
        end
        bus.wreq_valid = 1'b0;
        bus.rreq_valid = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 16; i++) do_write(7'(i), '1, pat(i));

        // Streaming reads: one response per cycle, two cycles behind the grant.
        for (int c = 0; c < 18; c++) begin
            bus.rreq_valid = (c < 16);
            bus.rreq_addr  = 7'(c);
            #1;
            if (c < 16) check($sformatf("stream_rdy%0d", c), bus.rreq_ready, 1'b1);
            check($sformatf("stream_vld%0d", c), bus.rresp_valid, c >= 2);
            if (c >= 2) check($sformatf("stream_dat%0d", c), bus.rresp_data, pat(c - 2));
            tick();
        end
        bus.rreq_valid = 1'b0;
        check("stream_end", bus.rresp_valid, 1'b0);

        // Backpressure: only two reads fit behind a stalled consumer.
        bus.rresp_ready = 1'b0;
        j = 0;
        for (int i = 0; i < 4; i++) begin
            bus.rreq_valid = 1'b1;
            bus.rreq_addr  = 7'(10 + j);
            #1;
            check($sformatf("bp_rdy%0d", i), bus.rreq_ready, i < 2);
            if (bus.rreq_ready) j++;
            tick();
        end
        bus.rreq_valid = 1'b0;
        check("bp_hold0", {bus.rresp_valid, bus.rresp_data}, {1'b1, pat(10)});
        tick();
        check("bp_hold1", {bus.rresp_valid, bus.rresp_data}, {1'b1, pat(10)});
        bus.rresp_ready = 1'b1;
        #1;
        check("bp_pop0", {bus.rresp_valid, bus.rresp_data}, {1'b1, pat(10)});
        tick();
        check("bp_pop1", {bus.rresp_valid, bus.rresp_data}, {1'b1, pat(11)});
        tick();
        check("bp_empty", bus.rresp_valid, 1'b0);

        // Reset in the middle of a stalled read burst.
        bus.rresp_ready = 1'b0;
        bus.rreq_valid  = 1'b1;
        bus.rreq_addr   = 7'd0;
        tick();
        bus.rreq_addr   = 7'd1;
        repeat (3) tick();
        check("burst_full", {bus.rresp_valid, bus.rreq_ready}, 2'b10);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outs("burst_rst");
        bus.rreq_valid  = 1'b0;
        bus.rresp_ready = 1'b1;
        release_and_check_init("burst_refill");
        check("burst_buf_empty", bus.rresp_valid, 1'b0);
        do_read(7'd1);
        get_resp("burst_rd1_zero", '0);

        // Reset while the zero-fill is at address 60.
        reset_n = 1'b0;
        #7;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 60; k++) @(negedge clock);
        #1;
        check("init60", {bus.sram_en, bus.sram_addr}, {1'b1, 7'd60});
        #1 reset_n = 1'b0;
        #1;
        check_reset_outs("init60_rst");
        release_and_check_init("init60_refill");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
